inference_sequencer: RTL
========================

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 17, the enabled-cycle latency from a row entering the datapath to its activation output.
REQ-002 SHALL have parameter N_ROWS, default 8, the number of weight rows per load.
REQ-003 SHALL have ports, clock and reset first: clk in 1, system clock; n_rst in 1, reset, synchronous active-low; one clock.
REQ-004 SHALL have ports: start in 1, begin job pulse; num_inputs in 7, input rows in the job; act_mode in 2, activation function for the job.
REQ-005 SHALL have ports: src_valid in 1, host row present; src_ready out 1, row consumed this cycle.
REQ-006 SHALL have ports: out_ready in 1, sink accepts a result; out_valid out 1, activations output valid.
REQ-007 SHALL have ports: start_weights out 1, datapath weight-load trigger; enable out 1, datapath advance.
REQ-008 SHALL have ports: data_zero out 1, force datapath input to zero; activation_mode out 2, registered act_mode.
REQ-009 SHALL have ports: busy out 1, job in progress; done out 1, one-cycle job complete; err out 1, sticky error.

Function
REQ-010 SHALL use states IDLE, W_WAIT, W_LOAD, STREAM, DRAIN, DONE.
REQ-011 IDLE: start=1 and num_inputs!=0 -> W_WAIT; latch num_inputs and act_mode; busy=1 from the next cycle.
REQ-012 IDLE: start=1 and num_inputs==0 -> set err, stay IDLE; start while not IDLE is ignored.
REQ-013 W_WAIT: on src_valid=1 -> W_LOAD; that cycle drive start_weights=1, src_ready=1, enable=1, and set weight count to 1.
REQ-014 W_LOAD: src_ready=enable=1 each cycle; count increments; after N_ROWS rows total -> STREAM; start_weights stays 0.
REQ-015 W_LOAD: src_valid=0 -> set err, abort to IDLE, busy=0, no done.
REQ-016 STREAM: a row is accepted when src_valid=1 and no output stall; that cycle src_ready=enable=1 and a valid token enters the token pipe.
REQ-017 STREAM: after num_inputs rows accepted -> DRAIN; src_valid=0 -> enable=0 (whole datapath holds).
REQ-018 Token pipe: PIPE_LAT-bit shift register, shifted only when enable=1; out_valid = tail bit AND enable.
REQ-019 Output stall: tail bit=1 and out_ready=0 -> enable=0 and src_ready=0 in every state.
REQ-020 DRAIN: data_zero=1, enable=1 unless stalled, zero tokens enter; when the token pipe is empty -> DONE.
REQ-021 DONE: done=1 for one cycle -> IDLE; busy=0 in IDLE and DONE.
REQ-022 Output count: exactly num_inputs out_valid beats per job, in acceptance order.
REQ-023 activation_mode SHALL change only on job start.
REQ-024 err SHALL clear only on reset or on an accepted start.
REQ-025 Counters: 7-bit row count, saturating compare only; no wrap for num_inputs up to 127.

Reset
REQ-026 n_rst=0 at a clock edge SHALL reset everything, even mid-job: state IDLE, counters 0, token pipe 0, activation_mode 0.
REQ-027 During and after reset, all outputs SHALL be 0 until the next start.

Structure
REQ-028 The state enum, PIPE_LAT and N_ROWS SHALL live in the shared package systolic_pkg.
REQ-029 The token pipe SHALL be one sub-module, valid_token_pipe (DEPTH, shift_en, token_in, token_out).

Verification
REQ-030 Nominal: start, num_inputs=3, src_valid always 1, out_ready=1 -> start_weights at the W_WAIT exit cycle; 8 load cycles; 3 stream cycles; first out_valid 17 cycles after the first stream row; 3 beats; then done.
REQ-031 Input gaps: src_valid toggled 1/0 during STREAM, num_inputs=4 -> enable low in every gap cycle; exactly 4 out_valid beats.
REQ-032 Backpressure: out_ready=0 for 5 cycles at the first result -> enable=0 and out_valid=0 for those 5 cycles; the result appears when out_ready returns; no beats lost.
REQ-033 Errors: num_inputs=0 -> err=1, busy=0. src_valid dropped at weight row 4 -> err=1, return to IDLE, no done; the next valid start clears err.
REQ-034 Reset mid-STREAM: n_rst=0 for one cycle -> all outputs 0 on the next cycle; a new job runs correctly afterward.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sequencer state encoding and default datapath geometry
package systolic_pkg;
  localparam int PIPE_LAT = 17;
  localparam int N_ROWS = 8;
  typedef enum logic [2:0] {IDLE, W_WAIT, W_LOAD, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/valid_token_pipe.sv
// valid_token_pipe: DEPTH-stage valid-token shift register that tracks rows through the datapath
// Ports: clk, n_rst (sync active-low); shift_en advances every stage; token_in enters stage 0;
// token_out is the last stage.
module valid_token_pipe #(
  parameter int DEPTH = 17
) (
  input  logic clk,
  input  logic n_rst,
  input  logic shift_en,
  input  logic token_in,
  output logic token_out
);
  logic [DEPTH-1:0] pipe_q;
  always_ff @(posedge clk) begin
    if (!n_rst) pipe_q <= '0;
    else if (shift_en) pipe_q <= (pipe_q << 1) | DEPTH'(token_in);
  end
  assign token_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: job FSM that loads weights, streams input rows and drains results of a systolic datapath
// Ports: clk, n_rst (sync active-low); start/num_inputs/act_mode begin a job; src_valid/src_ready
// host row handshake; out_ready/out_valid result handshake; start_weights, enable, data_zero and
// activation_mode steer the datapath; busy, done, err report job status.
module inference_sequencer
  import systolic_pkg::*;
#(
  parameter int PIPE_LAT = systolic_pkg::PIPE_LAT,
  parameter int N_ROWS = systolic_pkg::N_ROWS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [6:0] num_inputs,
  input  logic [1:0] act_mode,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       start_weights,
  output logic       enable,
  output logic       data_zero,
  output logic [1:0] activation_mode,
  output logic       busy,
  output logic       done,
  output logic       err
);
  state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d, oc_q, oc_d, n_q, n_d;
  logic [1:0] mode_q, mode_d;
  logic err_q, err_d, tail, stall, tok_in;

  valid_token_pipe #(.DEPTH(PIPE_LAT)) u_pipe (
    .clk(clk), .n_rst(n_rst), .shift_en(enable), .token_in(tok_in), .token_out(tail)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      oc_q <= '0;
      n_q <= '0;
      mode_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      oc_q <= oc_d;
      n_q <= n_d;
      mode_q <= mode_d;
      err_q <= err_d;
    end
  end

  // A result waiting at the tail with no sink freezes the whole datapath.
  assign stall = tail & ~out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    oc_d = oc_q;
    n_d = n_q;
    mode_d = mode_q;
    err_d = err_q;
    src_ready = 1'b0;
    enable = 1'b0;
    start_weights = 1'b0;
    data_zero = 1'b0;
    tok_in = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (num_inputs == 7'd0) err_d = 1'b1;
        else begin
          state_d = W_WAIT;
          n_d = num_inputs;
          mode_d = act_mode;
          err_d = 1'b0;
          cnt_d = '0;
          oc_d = '0;
        end
      end
      W_WAIT: if (src_valid && !stall) begin
        start_weights = 1'b1;
        src_ready = 1'b1;
        enable = 1'b1;
        cnt_d = (N_ROWS == 1) ? 7'd0 : 7'd1;
        state_d = (N_ROWS == 1) ? STREAM : W_LOAD;
      end
      W_LOAD: if (!src_valid) begin
        err_d = 1'b1;
        state_d = IDLE;
      end else if (!stall) begin
        src_ready = 1'b1;
        enable = 1'b1;
        cnt_d = (cnt_q == 7'(N_ROWS - 1)) ? 7'd0 : cnt_q + 7'd1;
        state_d = (cnt_q == 7'(N_ROWS - 1)) ? STREAM : W_LOAD;
      end
      STREAM: if (src_valid && !stall) begin
        src_ready = 1'b1;
        enable = 1'b1;
        tok_in = 1'b1;
        cnt_d = cnt_q + 7'd1;
        state_d = (cnt_q >= n_q - 7'd1) ? DRAIN : STREAM;
      end
      DRAIN: begin
        data_zero = 1'b1;
        enable = ~stall;
        // Every accepted row has left once the emitted-beat count reaches the job size.
        state_d = (oc_q == n_q) ? DONE : DRAIN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_valid = tail & enable;
    oc_d = out_valid ? oc_q + 7'd1 : oc_d;
  end

  assign activation_mode = mode_q;
  assign busy = state_q inside {W_WAIT, W_LOAD, STREAM, DRAIN};
  assign done = state_q == DONE;
  assign err = err_q;
endmodule
